// File: rtl/mono_data_tx_core.sv
// ---------------------------------------------------------------------------
// mono_data_tx_core
//
// Buffers pixel hits in a small FIFO and serialises them, one 30-bit word
// per read request, onto a single registered data line (MSB first).
// Word format: {le[7:0], te[7:0], row[7:0], col[5:0]}.
//
// Optional build macro: MONO_TX_GRAY_ENC_EN
//   defined   -> LE and TE are Gray-coded (g = b ^ (b >> 1)) as they are
//                written into the FIFO.
//   undefined -> LE and TE are stored and sent in binary.
//
// Parameters
//   FIFO_ASIZE : log2 of the hit buffer depth (depth = 2**FIFO_ASIZE).
//
// Ports
//   RX_CLK    in   single clock, rising edge
//   RST       in   asynchronous active-high reset
//   HIT_WR    in   hit write strobe (one hit per cycle)
//   HIT_COL   in   [5:0] hit column
//   HIT_ROW   in   [7:0] hit row
//   HIT_LE    in   [7:0] leading-edge timestamp (binary)
//   HIT_TE    in   [7:0] trailing-edge timestamp (binary)
//   RX_READ   in   asynchronous read request from the receiver
//   RX_FREEZE in   asynchronous freeze from the receiver
//   RX_TOKEN  out  registered hit-pending token
//   RX_DATA   out  registered serial data, MSB first
//   HIT_FULL  out  buffer full (combinational)
//   LOST_CNT  out  [7:0] saturating count of dropped hits
//   READ_ERR  out  sticky protocol-error flag
//   DBG_STATE out  [1:0] FSM state: 0 = IDLE, 1 = LOAD, 2 = SHIFT
//
// Handshake: there is no valid/ready pair on the receiver side. RX_READ
// and RX_FREEZE are levels from another clock domain; only the rising
// edge of their synchronised copies has meaning. A read edge in IDLE
// starts one word transfer (LOAD + 30 SHIFT cycles); a read edge while a
// transfer is in flight is dropped and flagged in READ_ERR. HIT_WR is
// accepted in any cycle where HIT_FULL is low and dropped otherwise.
// ---------------------------------------------------------------------------
module mono_data_tx_core #(
  parameter int FIFO_ASIZE = 4
) (
  input  logic       RX_CLK,
  input  logic       RST,
  input  logic       HIT_WR,
  input  logic [5:0] HIT_COL,
  input  logic [7:0] HIT_ROW,
  input  logic [7:0] HIT_LE,
  input  logic [7:0] HIT_TE,
  input  logic       RX_READ,
  input  logic       RX_FREEZE,
  output logic       RX_TOKEN,
  output logic       RX_DATA,
  output logic       HIT_FULL,
  output logic [7:0] LOST_CNT,
  output logic       READ_ERR,
  output logic [1:0] DBG_STATE
);

  localparam int DEPTH = 1 << FIFO_ASIZE;
  localparam logic [FIFO_ASIZE:0]   DEPTH_C = DEPTH;
  localparam logic [FIFO_ASIZE:0]   CNT_ONE = 1;
  localparam logic [FIFO_ASIZE-1:0] PTR_ONE = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  // synchronisers plus one extra stage for edge detection
  logic read_s1_q, read_s2_q, read_s3_q;
  logic freeze_s1_q, freeze_s2_q, freeze_s3_q;

  logic [29:0]           mem_q [DEPTH];
  logic [FIFO_ASIZE-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_ASIZE:0]   count_q, count_d;
  logic [FIFO_ASIZE:0]   avail_q, avail_d;

  state_t      state_q, state_d;
  logic [29:0] shift_q, shift_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic        rx_data_q, rx_data_d;
  logic        token_q, token_d;
  logic [7:0]  lost_q, lost_d;
  logic        err_q, err_d;

  logic        read_edge, freeze_edge, frozen;
  logic        full, empty, wr_en, can_pop, pop;
  logic [7:0]  le_enc, te_enc;
  logic [29:0] hit_word, load_word;

  assign read_edge   = read_s2_q & ~read_s3_q;
  assign freeze_edge = freeze_s2_q & ~freeze_s3_q;
  // Frozen behaviour starts the cycle after the freeze edge, which is
  // exactly when AVAIL holds the snapshot taken on that edge.
  assign frozen      = freeze_s3_q;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign wr_en   = HIT_WR & ~full;
  // While frozen only the snapshot entries may leave the buffer.
  assign can_pop = ~empty & (~frozen | (avail_q != '0));
  assign pop     = (state_q == ST_LOAD) & can_pop;

`ifdef MONO_TX_GRAY_ENC_EN
  assign le_enc = HIT_LE ^ (HIT_LE >> 1);
  assign te_enc = HIT_TE ^ (HIT_TE >> 1);
`else
  assign le_enc = HIT_LE;
  assign te_enc = HIT_TE;
`endif

  assign hit_word  = {le_enc, te_enc, HIT_ROW, HIT_COL};
  assign load_word = can_pop ? mem_q[rd_ptr_q] : '0;

  // FIFO storage needs no reset: pointers and occupancy define validity.
  always_ff @(posedge RX_CLK) begin
    if (wr_en) mem_q[wr_ptr_q] <= hit_word;
  end

  always_comb begin
    count_d = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Snapshot excludes a same-cycle write and is net of a same-cycle pop.
  always_comb begin
    avail_d = avail_q;
    if (freeze_edge)
      avail_d = pop ? (count_q - CNT_ONE) : count_q;
    else if (pop && frozen)
      avail_d = avail_q - CNT_ONE;
  end

  always_comb begin
    lost_d = lost_q;
    if (HIT_WR && full && (lost_q != 8'hFF)) lost_d = lost_q + 8'd1;
  end

  assign token_d = frozen ? (avail_q != '0) : ~empty;

  // Transfer FSM. RX_DATA is registered so that it shows shifter bit
  // (29 - bit_cnt) during each SHIFT cycle and 0 in every other state.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    rx_data_d = 1'b0;
    err_d     = err_q;
    if (read_edge && (state_q != ST_IDLE)) err_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (read_edge) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (!can_pop) err_d = 1'b1;
        rx_data_d = load_word[29];
        shift_d   = {load_word[28:0], 1'b0};
        bit_cnt_d = 5'd0;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (bit_cnt_q == 5'd29) begin
          state_d = ST_IDLE;
        end else begin
          rx_data_d = shift_q[29];
          shift_d   = {shift_q[28:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 5'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge RX_CLK or posedge RST) begin
    if (RST) begin
      read_s1_q   <= 1'b0;
      read_s2_q   <= 1'b0;
      read_s3_q   <= 1'b0;
      freeze_s1_q <= 1'b0;
      freeze_s2_q <= 1'b0;
      freeze_s3_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      avail_q     <= '0;
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      rx_data_q   <= 1'b0;
      token_q     <= 1'b0;
      lost_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      read_s1_q   <= RX_READ;
      read_s2_q   <= read_s1_q;
      read_s3_q   <= read_s2_q;
      freeze_s1_q <= RX_FREEZE;
      freeze_s2_q <= freeze_s1_q;
      freeze_s3_q <= freeze_s2_q;
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)   rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q     <= count_d;
      avail_q     <= avail_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_data_q   <= rx_data_d;
      token_q     <= token_d;
      lost_q      <= lost_d;
      err_q       <= err_d;
    end
  end

  assign RX_TOKEN  = token_q;
  assign RX_DATA   = rx_data_q;
  assign HIT_FULL  = full;
  assign LOST_CNT  = lost_q;
  assign READ_ERR  = err_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_mono_data_tx_core.sv
// ---------------------------------------------------------------------------
// tb_mono_data_tx_core
//
// Directed + randomised bench for mono_data_tx_core (FIFO_ASIZE = 4).
// The reference model is a queue of expected 30-bit words, a lost-hit
// counter, a frozen-snapshot count and a sticky error bit. Inputs are
// driven on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_mono_data_tx_core;

  localparam int ASIZE = 4;
  localparam int DEPTH = 1 << ASIZE;

  // clock / reset
  logic       rx_clk = 1'b0;
  logic       rst;
  logic       hit_wr;
  logic [5:0] hit_col;
  logic [7:0] hit_row, hit_le, hit_te;
  logic       rx_read, rx_freeze;
  logic       rx_token, rx_data, hit_full, read_err;
  logic [7:0] lost_cnt;
  logic [1:0] dbg_state;

  always #5 rx_clk = ~rx_clk;

  mono_data_tx_core #(.FIFO_ASIZE(ASIZE)) dut (
    .RX_CLK(rx_clk), .RST(rst), .HIT_WR(hit_wr), .HIT_COL(hit_col),
    .HIT_ROW(hit_row), .HIT_LE(hit_le), .HIT_TE(hit_te),
    .RX_READ(rx_read), .RX_FREEZE(rx_freeze), .RX_TOKEN(rx_token),
    .RX_DATA(rx_data), .HIT_FULL(hit_full), .LOST_CNT(lost_cnt),
    .READ_ERR(read_err), .DBG_STATE(dbg_state)
  );

  // scoreboard / reference model
  logic [29:0] exp_q[$];
  int          model_lost;
  int          model_avail;
  bit          model_frozen;
  bit          model_err;
  int          checks;
  int          errors;

  // hit written alongside a LOAD when requested by do_read
  logic [5:0]  pend_col;
  logic [7:0]  pend_row, pend_le, pend_te;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [29:0] mk_word(input logic [5:0] c, input logic [7:0] r,
                                          input logic [7:0] le, input logic [7:0] te);
    logic [7:0] l, t;
    l = le;
    t = te;
`ifdef MONO_TX_GRAY_ENC_EN
    l = le ^ (le >> 1);
    t = te ^ (te >> 1);
`endif
    return {l, t, r, c};
  endfunction

  function automatic logic model_token();
    if (model_frozen) return (model_avail != 0);
    return (exp_q.size() != 0);
  endfunction

  task automatic model_push(input logic [5:0] c, input logic [7:0] r,
                            input logic [7:0] le, input logic [7:0] te);
    if (exp_q.size() < DEPTH) exp_q.push_back(mk_word(c, r, le, te));
    else if (model_lost < 255) model_lost++;
  endtask

  task automatic model_pop(output logic [29:0] w);
    if ((exp_q.size() > 0) && (!model_frozen || (model_avail > 0))) begin
      w = exp_q.pop_front();
      if (model_frozen) model_avail--;
    end else begin
      w = '0;
      model_err = 1'b1;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    model_lost   = 0;
    model_avail  = 0;
    model_frozen = 1'b0;
    model_err    = 1'b0;
  endtask

  // driver tasks
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge rx_clk);
  endtask

  task automatic write_hit(input logic [5:0] c, input logic [7:0] r,
                           input logic [7:0] le, input logic [7:0] te);
    @(negedge rx_clk);
    hit_wr  = 1'b1;
    hit_col = c;
    hit_row = r;
    hit_le  = le;
    hit_te  = te;
    model_push(c, r, le, te);
    @(negedge rx_clk);
    hit_wr = 1'b0;
  endtask

  task automatic write_rand();
    write_hit(6'($urandom_range(0, 63)), 8'($urandom_range(0, 255)),
              8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
  endtask

  // One read transfer. The first bit is expected 4 clocks after RX_READ
  // rises. reedge_at / rst_at are bit positions (0 = first bit) at which
  // to raise a second read request or to assert reset; -1 disables.
  task automatic do_read(input logic [29:0] exp_word, input int reedge_at,
                         input int rst_at, input bit wr_at_load);
    @(negedge rx_clk);
    rx_read = 1'b1;
    @(negedge rx_clk);
    @(negedge rx_clk);
    rx_read = 1'b0;
    @(negedge rx_clk);
    check("state_load", 32'(dbg_state), 32'd1);
    if (wr_at_load) begin
      hit_wr  = 1'b1;
      hit_col = pend_col;
      hit_row = pend_row;
      hit_le  = pend_le;
      hit_te  = pend_te;
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge rx_clk);
      hit_wr = 1'b0;
      check($sformatf("rx_data_bit%0d", 29 - i), 32'(rx_data), 32'(exp_word[29 - i]));
      check("state_shift", 32'(dbg_state), 32'd2);
      if (i == reedge_at)     rx_read = 1'b1;
      if (i == reedge_at + 2) rx_read = 1'b0;
      if (i == rst_at) begin
        rst = 1'b1;
        #1;
        check("rst_async_data", 32'(rx_data), 32'd0);
        check("rst_async_token", 32'(rx_token), 32'd0);
        check("rst_async_state", 32'(dbg_state), 32'd0);
        check("rst_async_lost", 32'(lost_cnt), 32'd0);
        @(negedge rx_clk);
        check("rst_clk_data", 32'(rx_data), 32'd0);
        check("rst_clk_token", 32'(rx_token), 32'd0);
        check("rst_clk_state", 32'(dbg_state), 32'd0);
        check("rst_clk_lost", 32'(lost_cnt), 32'd0);
        rst = 1'b0;
        model_reset();
        return;
      end
    end
    @(negedge rx_clk);
    check("post_shift_data", 32'(rx_data), 32'd0);
    check("post_shift_state", 32'(dbg_state), 32'd0);
  endtask

  initial begin
    logic [29:0] w;
    logic [29:0] exp_vec;
    int          n;

    checks = 0;
    errors = 0;
    model_reset();
    rst = 1'b1;
    hit_wr = 1'b0;
    hit_col = '0;
    hit_row = '0;
    hit_le = '0;
    hit_te = '0;
    rx_read = 1'b0;
    rx_freeze = 1'b0;
    pend_col = '0;
    pend_row = '0;
    pend_le = '0;
    pend_te = '0;
    idle(3);
    check("reset_token", 32'(rx_token), 32'd0);
    check("reset_data", 32'(rx_data), 32'd0);
    check("reset_full", 32'(hit_full), 32'd0);
    check("reset_lost", 32'(lost_cnt), 32'd0);
    check("reset_err", 32'(read_err), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    idle(2);

    // fixed vector COL=3 ROW=10 LE=5 TE=200
`ifdef MONO_TX_GRAY_ENC_EN
    exp_vec = {8'h07, 8'hAC, 8'h0A, 6'b000011};
`else
    exp_vec = {8'h05, 8'hC8, 8'h0A, 6'b000011};
`endif
    write_hit(6'd3, 8'd10, 8'd5, 8'd200);
    idle(2);
    check("vec_token", 32'(rx_token), 32'd1);
    model_pop(w);
    do_read(exp_vec, -1, -1, 1'b0);
    idle(2);
    check("vec_token_after", 32'(rx_token), 32'd0);
    check("vec_err", 32'(read_err), 32'(model_err));

    // random bursts
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) write_rand();
      idle(2);
      check("rand_token", 32'(rx_token), 32'(model_token()));
      for (int k = 0; k < n; k++) begin
        model_pop(w);
        do_read(w, -1, -1, 1'b0);
      end
      idle(2);
      check("rand_token_empty", 32'(rx_token), 32'(model_token()));
    end

    // freeze: 3 before, 2 during, 3 reads
    for (int k = 0; k < 3; k++) write_rand();
    @(negedge rx_clk);
    rx_freeze = 1'b1;
    model_frozen = 1'b1;
    model_avail = exp_q.size();
    idle(5);
    for (int k = 0; k < 2; k++) write_rand();
    idle(2);
    check("frz_token", 32'(rx_token), 32'(model_token()));
    for (int k = 0; k < 3; k++) begin
      model_pop(w);
      do_read(w, -1, -1, 1'b0);
      idle(1);
      check("frz_token_read", 32'(rx_token), 32'(model_token()));
    end
    check("frz_token_zero", 32'(rx_token), 32'd0);
    @(negedge rx_clk);
    rx_freeze = 1'b0;
    model_frozen = 1'b0;
    idle(5);
    check("unfrz_token", 32'(rx_token), 32'd1);
    check("unfrz_model_cnt", 32'(exp_q.size()), 32'd2);
    for (int k = 0; k < 2; k++) begin
      model_pop(w);
      do_read(w, -1, -1, 1'b0);
    end
    idle(2);
    check("unfrz_token_empty", 32'(rx_token), 32'(model_token()));
    check("frz_err", 32'(read_err), 32'(model_err));

    // fill: 20 hits, 4 dropped
    for (int k = 0; k < 20; k++) write_rand();
    idle(1);
    check("fill_full", 32'(hit_full), 32'd1);
    check("fill_lost4", 32'(lost_cnt), 32'd4);
    check("fill_lost_model", 32'(lost_cnt), 32'(model_lost));
    model_pop(w);
    do_read(w, -1, -1, 1'b0);
    check("fill_not_full", 32'(hit_full), 32'd0);
    // write coinciding with the LOAD pop at occupancy DEPTH-1
    pend_col = 6'($urandom_range(0, 63));
    pend_row = 8'($urandom_range(0, 255));
    pend_le  = 8'($urandom_range(0, 255));
    pend_te  = 8'($urandom_range(0, 255));
    model_pop(w);
    model_push(pend_col, pend_row, pend_le, pend_te);
    do_read(w, -1, -1, 1'b1);
    check("wrpop_not_full", 32'(hit_full), 32'd0);
    check("wrpop_lost", 32'(lost_cnt), 32'(model_lost));
    write_rand();
    idle(1);
    check("wrpop_full_again", 32'(hit_full), 32'd1);
    check("wrpop_lost_same", 32'(lost_cnt), 32'd4);
    write_rand();
    check("drop_lost5", 32'(lost_cnt), 32'(model_lost));
    for (int k = 0; k < 300; k++) write_rand();
    idle(1);
    check("sat_lost", 32'(lost_cnt), 32'd255);
    for (int k = 0; k < DEPTH; k++) begin
      model_pop(w);
      do_read(w, -1, -1, 1'b0);
    end
    idle(2);
    check("drain_token", 32'(rx_token), 32'(model_token()));
    check("drain_full", 32'(hit_full), 32'd0);
    check("drain_err", 32'(read_err), 32'(model_err));

    // reset in the middle of a shift
    for (int k = 0; k < 3; k++) write_rand();
    idle(2);
    check("prerst_token", 32'(rx_token), 32'd1);
    model_pop(w);
    do_read(w, -1, 15, 1'b0);
    idle(2);
    check("postrst_token", 32'(rx_token), 32'(model_token()));
    check("postrst_full", 32'(hit_full), 32'd0);
    check("postrst_err", 32'(read_err), 32'd0);

    // empty read plus a second request 10 bits into the shift
    model_pop(w);
    model_err = 1'b1;
    do_read(w, 10, -1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      @(negedge rx_clk);
      check("extra_read_state", 32'(dbg_state), 32'd0);
      check("extra_read_data", 32'(rx_data), 32'd0);
    end
    check("empty_read_err", 32'(read_err), 32'(model_err));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
